pulse_capture_buffer: RTL
=========================

Name: pulse_capture_buffer

Overview:
Parametrised successor of the single-pulse I/Q receiver. Arms on START, skips a programmable number of DDC samples, then captures PULSE_LEN I/Q sample pairs into an internal buffer. Streams the captured words out over a valid/ready readout port, then pulses RECEIVE_OVER. Sits between the DDC output (I/Q plus VALID strobe) and the host/readout logic, all in the CLK domain.

Parameters:
DATA_W, 16, width of each I and Q sample
DEPTH, 1024, buffer depth in I/Q pairs; power of two, at least 2
ADDR_W, 10, buffer index width; must equal log2(DEPTH)
LEN_W, 16, width of PULSE_LEN, DELAY_LEN and ADDR_OUT

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
START  in  1  one-cycle arm request; honoured only in IDLE
ABORT  in  1  cancel request; takes priority over all other inputs
PULSE_LEN  in  LEN_W  number of sample pairs to capture
DELAY_LEN  in  LEN_W  number of VALID strobes to discard before capture
I_DATA  in  DATA_W  in-phase sample from DDC
Q_DATA  in  DATA_W  quadrature sample from DDC
VALID  in  1  sample strobe; I_DATA/Q_DATA valid when high
RD_READY  in  1  readout consumer ready
TR_OUT  out  1  readout word valid
ADDR_OUT  out  LEN_W  sample index of DATA_OUT, zero-extended
DATA_OUT  out  2*DATA_W  captured word {Q, I}
RECEIVE_OVER  out  1  one-cycle pulse after the last readout handshake
BUSY  out  1  high in every state except IDLE
LEN_CLAMPED  out  1  high when the latched PULSE_LEN exceeded DEPTH

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE; counters clear. Buffer contents are not reset. Reset mid-operation discards the capture, and no RECEIVE_OVER is generated.
- FSM states: IDLE, DELAY, CAPTURE, READOUT, DONE.
- IDLE, START=1:
  - Latch N = min(PULSE_LEN, DEPTH) and D = DELAY_LEN.
  - LEN_CLAMPED <= (PULSE_LEN > DEPTH); it holds until the next accepted START.
  - If N=0, go to DONE.
  - Otherwise go to DELAY if D>0, or CAPTURE if D=0.
  - A VALID in the same cycle as START is neither counted nor captured.
- DELAY: each VALID increments the skip count. On the D-th VALID, go to CAPTURE; that sample is not captured.
- CAPTURE:
  - Each VALID writes {Q_DATA, I_DATA} at wr_ptr and increments wr_ptr.
  - On the write with wr_ptr = N-1, go to READOUT. With N = DEPTH, wr_ptr reaches DEPTH-1 and does not wrap.
  - VALID may be high on consecutive cycles; every strobe is captured.
- READOUT:
  - Buffer is synchronous-read RAM with 1-cycle latency.
  - Prefetch/skid logic must give the first TR_OUT no later than 2 cycles after entering READOUT.
  - Sustain one word per cycle while RD_READY=1.
  - Words are presented in index order 0..N-1, with ADDR_OUT equal to the index.
  - A handshake is TR_OUT & RD_READY. While TR_OUT=1 and RD_READY=0, TR_OUT, ADDR_OUT and DATA_OUT hold stable.
  - VALID is ignored in READOUT.
  - After the handshake of index N-1, TR_OUT drops the next cycle and the FSM goes to DONE.
- DONE: RECEIVE_OVER=1 for exactly one cycle, then IDLE. In IDLE, ADDR_OUT and DATA_OUT keep their last values.
- ABORT=1 in any state:
  - Next cycle: IDLE, TR_OUT=0, BUSY=0, no RECEIVE_OVER.
  - If START and ABORT coincide in IDLE, ABORT wins and the START is dropped.
- START outside IDLE is ignored; a new capture needs a fresh START after BUSY falls.
- PULSE_LEN and DELAY_LEN changes after START have no effect on the current capture.

Test Plan:
- DELAY_LEN=3, PULSE_LEN=8, VALID every 4th cycle, I=k, Q=0x100+k for the k-th strobe (k from 0), RD_READY=1:
  - Samples k=3..10 are captured.
  - ADDR_OUT runs 0..7 with DATA_OUT={0x100+k, k}, TR_OUT high for 8 consecutive cycles, then a single RECEIVE_OVER.
- PULSE_LEN=2000, DEPTH=1024, DELAY_LEN=0, VALID held high:
  - LEN_CLAMPED=1.
  - Exactly 1024 words are read, last ADDR_OUT=1023, then RECEIVE_OVER.
- RD_READY toggles pseudo-randomly at 50% during readout of PULSE_LEN=16:
  - Every word is delivered once, in order, and held stable while stalled.
  - No word is lost or duplicated.
- PULSE_LEN=0, START:
  - RECEIVE_OVER pulses within 2 cycles.
  - TR_OUT never asserts and BUSY falls afterwards.
- ABORT mid-CAPTURE (after 5 of 10 samples):
  - IDLE next cycle, no TR_OUT and no RECEIVE_OVER.
  - A following START with PULSE_LEN=4 captures and reads fresh samples at indices 0..3.
- RESET_N low during READOUT, then released and START with PULSE_LEN=4:
  - All outputs are 0 while reset is low.
  - The new capture completes normally; a START applied while BUSY=1 is ignored.

Source files
------------

// File: rtl/pulse_capture_buffer.sv
// Single-pulse I/Q capture: arm on START, skip DELAY_LEN strobes, store PULSE_LEN {Q,I}
// pairs, then stream them out over a valid/ready port and pulse RECEIVE_OVER.
module pulse_capture_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                START,
  input  logic                ABORT,
  input  logic [LEN_W-1:0]    PULSE_LEN,
  input  logic [LEN_W-1:0]    DELAY_LEN,
  input  logic [DATA_W-1:0]   I_DATA,
  input  logic [DATA_W-1:0]   Q_DATA,
  input  logic                VALID,
  input  logic                RD_READY,
  output logic                TR_OUT,
  output logic [LEN_W-1:0]    ADDR_OUT,
  output logic [2*DATA_W-1:0] DATA_OUT,
  output logic                RECEIVE_OVER,
  output logic                BUSY,
  output logic                LEN_CLAMPED
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DELAY   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_READOUT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  logic [2:0]          state;
  logic [LEN_W-1:0]    n_len;
  logic [LEN_W-1:0]    d_len;
  logic [LEN_W-1:0]    skip_cnt;
  logic [LEN_W-1:0]    wr_ptr;
  logic [LEN_W-1:0]    rd_idx;

  logic [2*DATA_W-1:0] mem [DEPTH];

  logic [2*DATA_W-1:0] rdata_p1;
  logic [LEN_W-1:0]    addr_p1;
  logic                vld_p1;
  logic [2*DATA_W-1:0] skid_data_p2;
  logic [LEN_W-1:0]    skid_addr_p2;
  logic                skid_vld_p2;

  logic                pop;
  logic                rd_issue;
  logic                last_pop;
  logic [1:0]          occ;

  assign BUSY = (state != S_IDLE);

  // Readout issue: keep at most two words (output + skid) owned at any time,
  // counting the one in flight through the RAM.
  always_comb begin
    pop      = TR_OUT & RD_READY;
    occ      = {1'b0, TR_OUT} + {1'b0, skid_vld_p2} + {1'b0, vld_p1};
    rd_issue = (state == S_READOUT) && !ABORT && (rd_idx < n_len) &&
               ((occ - {1'b0, pop}) < 2'd2);
    last_pop = pop && (ADDR_OUT == (n_len - ONE_L));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_IDLE;
      n_len        <= '0;
      d_len        <= '0;
      skip_cnt     <= '0;
      wr_ptr       <= '0;
      rd_idx       <= '0;
      LEN_CLAMPED  <= 1'b0;
      RECEIVE_OVER <= 1'b0;
      vld_p1       <= 1'b0;
      skid_vld_p2  <= 1'b0;
      TR_OUT       <= 1'b0;
      ADDR_OUT     <= '0;
      DATA_OUT     <= '0;
    end else begin
      RECEIVE_OVER <= 1'b0;
      vld_p1       <= rd_issue;
      if (rd_issue) rd_idx <= rd_idx + ONE_L;
      if (ABORT) begin
        state       <= S_IDLE;
        TR_OUT      <= 1'b0;
        skid_vld_p2 <= 1'b0;
        vld_p1      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (START) begin
              n_len       <= (PULSE_LEN > DEPTH_L) ? DEPTH_L : PULSE_LEN;
              d_len       <= DELAY_LEN;
              LEN_CLAMPED <= (PULSE_LEN > DEPTH_L);
              skip_cnt    <= '0;
              wr_ptr      <= '0;
              rd_idx      <= '0;
              if (PULSE_LEN == '0) begin
                state        <= S_DONE;
                RECEIVE_OVER <= 1'b1;
              end else if (DELAY_LEN != '0) begin
                state <= S_DELAY;
              end else begin
                state <= S_CAPTURE;
              end
            end
          end
          S_DELAY: begin
            if (VALID) begin
              skip_cnt <= skip_cnt + ONE_L;
              if (skip_cnt == (d_len - ONE_L)) state <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (VALID) begin
              wr_ptr <= wr_ptr + ONE_L;
              if (wr_ptr == (n_len - ONE_L)) state <= S_READOUT;
            end
          end
          S_READOUT: begin
            if (last_pop) begin
              state        <= S_DONE;
              RECEIVE_OVER <= 1'b1;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase

        // Stage p2: output register fed from skid first, then straight from RAM.
        if (!TR_OUT || pop) begin
          if (skid_vld_p2) begin
            TR_OUT      <= 1'b1;
            DATA_OUT    <= skid_data_p2;
            ADDR_OUT    <= skid_addr_p2;
            skid_vld_p2 <= vld_p1;
          end else if (vld_p1) begin
            TR_OUT   <= 1'b1;
            DATA_OUT <= rdata_p1;
            ADDR_OUT <= addr_p1;
          end else begin
            TR_OUT <= 1'b0;
          end
        end else if (vld_p1) begin
          skid_vld_p2 <= 1'b1;
        end
      end
    end
  end

  // Stage p1: buffer RAM and read-data/skid datapath, no reset.
  always_ff @(posedge CLK) begin
    if (state == S_CAPTURE && VALID && !ABORT) mem[wr_ptr[ADDR_W-1:0]] <= {Q_DATA, I_DATA};
    if (rd_issue) begin
      rdata_p1 <= mem[rd_idx[ADDR_W-1:0]];
      addr_p1  <= rd_idx;
    end
    if (vld_p1 && (skid_vld_p2 || (TR_OUT && !pop))) begin
      skid_data_p2 <= rdata_p1;
      skid_addr_p2 <= addr_p1;
    end
  end

endmodule
